fp32_div_seq: RTL and testbench

Sequential IEEE-754 single-precision divider: quotient = x / y. It is the inverse-operation companion to the combinational FP32 multiplier and shares the same format and normalisation rules. Subnormal inputs are treated as zero.
- Restoring mantissa division, one quotient bit per cycle.
- Valid/ready handshake on input and output.
- Fixed latency, independent of operand values.

---
 rtl/fp32_pkg.sv | 38 +++
 rtl/fp32_classify.sv | 22 ++
 rtl/fp32_div_seq.sv | 210 +++++++++++++++++++++
 tb/tb_fp32_div_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: operand layout, constants, divider state encoding and flag bit positions.
package fp32_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned SIG_W  = MAN_W + 1;
    localparam int unsigned Q_W    = 27;
    localparam int unsigned REM_W  = SIG_W + 1;
    localparam int unsigned E_W    = 10;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned FLAG_W = 4;

    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] PINF = 32'h7F80_0000;

    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_DIVZERO   = 2;
    localparam int unsigned FLAG_OVERFLOW  = 1;
    localparam int unsigned FLAG_UNDERFLOW = 0;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 operand classifier; subnormals are reported as zero.
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [FP_W-2:0] mag,
    output logic            is_zero,
    output logic            is_inf,
    output logic            is_nan
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] mant_f;

    // Sign has no bearing on the class, so only the magnitude field is taken.
    assign exp_f   = mag[FP_W-2:MAN_W];
    assign mant_f  = mag[MAN_W-1:0];

    assign is_zero = (exp_f == '0);
    assign is_inf  = (exp_f == EXP_W'(EXP_MAX)) && (mant_f == '0);
    assign is_nan  = (exp_f == EXP_W'(EXP_MAX)) && (mant_f != '0);

endmodule

// File: rtl/fp32_div_seq.sv
// Sequential FP32 divider: restoring mantissa division, one quotient bit per cycle, fixed latency.
module fp32_div_seq
    import fp32_pkg::*;
#(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP_W-1:0]   x,
    input  logic [FP_W-1:0]   y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP_W-1:0]   quotient,
    output logic [FLAG_W-1:0] flags
);

    fp32_t xf, yf;
    logic  x_zero, x_inf, x_nan, y_zero, y_inf, y_nan;

    assign xf = fp32_t'(x);
    assign yf = fp32_t'(y);

    fp32_classify u_cls_x (.mag(x[FP_W-2:0]), .is_zero(x_zero), .is_inf(x_inf), .is_nan(x_nan));
    fp32_classify u_cls_y (.mag(y[FP_W-2:0]), .is_zero(y_zero), .is_inf(y_inf), .is_nan(y_nan));

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [SIG_W-1:0]   mb_q, mb_d;
    logic [Q_W-1:0]     q_q, q_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   ea_q, ea_d, eb_q, eb_d;
    logic               spec_q, spec_d;
    logic [FP_W-1:0]    spec_res_q, spec_res_d;
    logic [FLAG_W-1:0]  spec_flags_q, spec_flags_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [FP_W-1:0]    quotient_q, quotient_d;
    logic [FLAG_W-1:0]  flags_q, flags_d;

    // Special-operand outcome, decided from the raw inputs at capture time.
    logic              sign_in, spec_hit;
    logic [FP_W-1:0]   spec_res;
    logic [FLAG_W-1:0] spec_flags;

    assign sign_in = xf.sign ^ yf.sign;

    always_comb begin
        spec_hit   = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            spec_res                 = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
        end else if (y_zero) begin
            spec_res                 = PINF | {sign_in, 31'd0};
            spec_flags[FLAG_DIVZERO] = 1'b1;
        end else if (x_inf) begin
            spec_res = PINF | {sign_in, 31'd0};
        end else if (x_zero || y_inf) begin
            spec_res = {sign_in, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // One restoring step: subtract divisor when it fits, then shift for the next bit.
    logic             quo_bit;
    logic [REM_W-1:0] rem_sel;

    assign quo_bit = (rem_q >= REM_W'(mb_q));
    assign rem_sel = quo_bit ? (rem_q - REM_W'(mb_q)) : rem_q;

    // Normalise, round and pack from the finished quotient bits.
    logic [MAN_W-1:0]   mant_raw;
    logic               guard, sticky, round_up;
    logic [SIG_W-1:0]   mant_sum;
    logic signed [E_W-1:0] e_pre, e_fin;
    logic [FP_W-1:0]    rnd_res;
    logic [FLAG_W-1:0]  rnd_flags;

    always_comb begin
        if (q_q[Q_W-1]) begin
            mant_raw = q_q[Q_W-2:3];
            guard    = q_q[2];
            sticky   = (|q_q[1:0]) | (rem_q != '0);
            e_pre    = $signed(E_W'(ea_q)) - $signed(E_W'(eb_q)) + $signed(E_W'(BIAS));
        end else begin
            mant_raw = q_q[Q_W-3:2];
            guard    = q_q[1];
            sticky   = q_q[0] | (rem_q != '0);
            e_pre    = $signed(E_W'(ea_q)) - $signed(E_W'(eb_q)) + $signed(E_W'(BIAS - 1));
        end
        round_up  = ROUND_EN && guard && (sticky || mant_raw[0]);
        mant_sum  = SIG_W'(mant_raw) + SIG_W'(round_up);
        e_fin     = e_pre + $signed(E_W'(mant_sum[SIG_W-1]));
        rnd_flags = '0;
        if (e_fin >= $signed(E_W'(EXP_MAX))) begin
            rnd_res                   = PINF | {sign_q, 31'd0};
            rnd_flags[FLAG_OVERFLOW]  = 1'b1;
        end else if (e_fin <= $signed(E_W'(0))) begin
            rnd_res                   = {sign_q, 31'd0};
            rnd_flags[FLAG_UNDERFLOW] = 1'b1;
        end else begin
            rnd_res = {sign_q, e_fin[EXP_W-1:0], mant_sum[MAN_W-1:0]};
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        mb_d         = mb_q;
        q_d          = q_q;
        sign_d       = sign_q;
        ea_d         = ea_q;
        eb_d         = eb_q;
        spec_d       = spec_q;
        spec_res_d   = spec_res_q;
        spec_flags_d = spec_flags_q;
        quotient_d   = quotient_q;
        flags_d      = flags_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d      = DIV;
                    cnt_d        = CNT_W'(Q_W - 1);
                    rem_d        = REM_W'({!x_zero, xf.mant});
                    mb_d         = {!y_zero, yf.mant};
                    q_d          = '0;
                    sign_d       = sign_in;
                    ea_d         = xf.exp;
                    eb_d         = yf.exp;
                    spec_d       = spec_hit;
                    spec_res_d   = spec_res;
                    spec_flags_d = spec_flags;
                end
            end
            DIV: begin
                q_d   = {q_q[Q_W-2:0], quo_bit};
                rem_d = REM_W'({rem_sel, 1'b0});
                if (cnt_q == '0) begin
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ROUND: begin
                state_d    = DONE;
                quotient_d = spec_q ? spec_res_q : rnd_res;
                flags_d    = spec_q ? spec_flags_q : rnd_flags;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            mb_q         <= '0;
            q_q          <= '0;
            sign_q       <= 1'b0;
            ea_q         <= '0;
            eb_q         <= '0;
            spec_q       <= 1'b0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            quotient_q   <= '0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            mb_q         <= mb_d;
            q_q          <= q_d;
            sign_q       <= sign_d;
            ea_q         <= ea_d;
            eb_q         <= eb_d;
            spec_q       <= spec_d;
            spec_res_q   <= spec_res_d;
            spec_flags_q <= spec_flags_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            quotient_q   <= quotient_d;
            flags_q      <= flags_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Scoreboard bench for fp32_div_seq: rounding and truncating instances driven in lockstep.
module tb_fp32_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] x, y;
    logic        out_ready;

    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [31:0] quotient1, quotient0;
    logic [3:0]  flags1, flags0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [35:0] q1[$];
    logic [35:0] q0[$];
    logic [35:0] e1, e0;

    always #5 clk = ~clk;

    fp32_div_seq #(.ROUND_EN(1'b1)) dut_rne (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .x(x), .y(y), .out_valid(out_valid1), .out_ready(out_ready),
        .quotient(quotient1), .flags(flags1)
    );

    fp32_div_seq #(.ROUND_EN(1'b0)) dut_trunc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .x(x), .y(y), .out_valid(out_valid0), .out_ready(out_ready),
        .quotient(quotient0), .flags(flags0)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitors: pop expected result on each output handshake.
    always @(negedge clk) begin
        if (out_valid1 && out_ready) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL rne_unexpected: got %h/%b with no result pending", quotient1, flags1);
            end else begin
                e1 = q1.pop_front();
                if ({quotient1, flags1} !== e1) begin
                    n_fail++;
                    $display("FAIL rne_result: got %h/%b expected %h/%b", quotient1, flags1, e1[35:4], e1[3:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid0 && out_ready) begin
            n_checks++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL trunc_unexpected: got %h/%b with no result pending", quotient0, flags0);
            end else begin
                e0 = q0.pop_front();
                if ({quotient0, flags0} !== e0) begin
                    n_fail++;
                    $display("FAIL trunc_result: got %h/%b expected %h/%b", quotient0, flags0, e0[35:4], e0[3:0]);
                end
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r1, input logic [3:0] f1,
                          input logic [31:0] r0, input logic [3:0] f0,
                          input int hold);
        int w;
        int lat;
        bit ir_bad;
        w = 0;
        while (!in_ready1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_before_op", 64'(in_ready1), 64'(1));
        x        = a;
        y        = b;
        in_valid = 1'b1;
        q1.push_back({r1, f1});
        q0.push_back({r0, f0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 0;
        ir_bad   = 1'b0;
        while (!out_valid1 && lat < 40) begin
            if (in_ready1 || in_ready0) ir_bad = 1'b1;
            @(posedge clk); #1; lat++;
        end
        check("latency", 64'(lat), 64'(28));
        check("in_ready_busy", 64'(ir_bad), 64'(0));
        check("out_valid_lockstep", 64'(out_valid0), 64'(1));
        for (int i = 0; i < hold; i++) begin
            check("hold_result", 64'({quotient1, flags1}), 64'({r1, f1}));
            check("hold_in_ready", 64'({in_ready1, out_valid1}), 64'(2'b01));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("after_handshake", 64'({in_ready1, out_valid1}), 64'(2'b10));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit stale;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'({in_ready1, out_valid1, quotient1, flags1}),
              64'({1'b1, 1'b0, 32'h0, 4'h0}));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Normal arithmetic, exact and rounded.
        run_op(32'h3FC0_0000, 32'h3F00_0000, 32'h4040_0000, 4'b0000, 32'h4040_0000, 4'b0000, 0);
        run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 32'h3EAA_AAAA, 4'b0000, 0);
        run_op(32'h40C0_0000, 32'hC000_0000, 32'hC040_0000, 4'b0000, 32'hC040_0000, 4'b0000, 5);
        // Special operands.
        run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100, 32'h7F80_0000, 4'b0100, 0);
        run_op(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0100, 32'hFF80_0000, 4'b0100, 0);
        run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 32'h7FC0_0000, 4'b1000, 0);
        run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 32'h7FC0_0000, 4'b1000, 0);
        run_op(32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0000, 32'h7F80_0000, 4'b0000, 0);
        run_op(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b1000, 32'h7FC0_0000, 4'b1000, 0);
        run_op(32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 4'b0000, 32'h8000_0000, 4'b0000, 0);
        run_op(32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 4'b0000, 0);
        // Range limits.
        run_op(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b0010, 32'h7F80_0000, 4'b0010, 0);
        run_op(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0001, 32'h0000_0000, 4'b0001, 0);
        run_op(32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, 4'b0000, 32'h3F2A_AAAA, 4'b0000, 3);

        // Reset in the middle of the division discards the operation.
        x        = 32'h4120_0000;
        y        = 32'h4040_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_op_reset", 64'({in_ready1, out_valid1, quotient1, flags1}),
              64'({1'b1, 1'b0, 32'h0, 4'h0}));
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid1 || out_valid0) stale = 1'b1;
        end
        out_ready = 1'b0;
        check("no_stale_result", 64'(stale), 64'(0));

        run_op(32'h4120_0000, 32'h4120_0000, 32'h3F80_0000, 4'b0000, 32'h3F80_0000, 4'b0000, 0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(q1.size() + q0.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
